ir_cmd_controller: RTL and testbench

IR_CMD_CONTROLLER -- requirements
Module: ir_cmd_controller

---
 rtl/ir_pkg.sv | 32 +++
 rtl/ir_cmd_fifo.sv | 75 +++++++
 rtl/ir_cmd_controller.sv | 169 ++++++++++++++++
 tb/tb_ir_cmd_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and constants for the NEC IR command controller.
// Frame layout, queue geometry and default tuning values live here.
package ir_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } ir_state_e;

    // NEC frame field bit positions inside the 32-bit frame word
    localparam int ADDR_HI   = 31;
    localparam int ADDR_LO   = 24;
    localparam int ADDR_N_HI = 23;
    localparam int ADDR_N_LO = 16;
    localparam int CMD_HI    = 15;
    localparam int CMD_LO    = 8;
    localparam int CMD_N_HI  = 7;
    localparam int CMD_N_LO  = 0;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_WIDTH = 9;

    localparam logic [7:0] DEF_ADDR_MATCH   = 8'h00;
    localparam int         DEF_HOLD_TIMEOUT = 5_500_000;
    localparam int         DEF_REPEAT_DELAY = 3;

    // A byte and its transmitted complement must differ in every bit.
    function automatic logic field_ok(input logic [7:0] val, input logic [7:0] inv);
        return ((val ^ inv) == 8'hFF);
    endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// Small register-based command queue; push while full is accepted only
// when a pop happens in the same cycle.
module ir_cmd_fifo
    import ir_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_pop_s  = pop && (count_q != {CNT_W{1'b0}});
        do_push_s = push && ((count_q != CNT_FULL) || do_pop_s);
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/ir_cmd_controller.sv
// NEC IR command controller: validates frames, tracks key hold/auto-repeat
// and queues commands. Optional address check via macro IR_ADDR_FILTER_EN.
module ir_cmd_controller
    import ir_pkg::*;
#(
    parameter logic [7:0] ADDR_MATCH   = DEF_ADDR_MATCH,
    parameter int         HOLD_TIMEOUT = DEF_HOLD_TIMEOUT,
    parameter int         REPEAT_DELAY = DEF_REPEAT_DELAY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [31:0] frame_data,
    input  logic        repeat_valid,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_data,
    output logic        cmd_repeat,
    output logic        err_pulse,
    output logic [7:0]  drop_cnt,
    output logic        key_held
);

    localparam int TMO_W = (HOLD_TIMEOUT > 2) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HOLD_TIMEOUT - 1);

    ir_state_e   state_q, state_d;
    logic [7:0]  last_cmd_q, last_cmd_d;
    logic [3:0]  rep_cnt_q, rep_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic        push_q, push_d;
    logic [8:0]  push_data_q, push_data_d;
    logic        err_q, err_d;
    logic        held_q, held_d;
    logic [7:0]  drop_q, drop_d;

    logic [7:0]  cmd_s;
    logic        frame_ok_s;
    logic        pop_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [8:0]  fifo_rd_s;

    assign cmd_s = frame_data[CMD_HI:CMD_LO];

`ifdef IR_ADDR_FILTER_EN
    assign frame_ok_s = field_ok(cmd_s, frame_data[CMD_N_HI:CMD_N_LO])
                     && field_ok(frame_data[ADDR_HI:ADDR_LO], frame_data[ADDR_N_HI:ADDR_N_LO])
                     && (frame_data[ADDR_HI:ADDR_LO] == ADDR_MATCH);
`else
    logic unused_addr_s;
    assign unused_addr_s = ^{frame_data[ADDR_HI:ADDR_N_LO], ADDR_MATCH};
    assign frame_ok_s    = field_ok(cmd_s, frame_data[CMD_N_HI:CMD_N_LO]);
`endif

    assign pop_s = !fifo_empty_s && cmd_ready;

    // Validation, hold/repeat FSM and drop accounting next-state
    always_comb begin
        state_d     = state_q;
        last_cmd_d  = last_cmd_q;
        rep_cnt_d   = rep_cnt_q;
        tmo_d       = tmo_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        err_d       = 1'b0;
        drop_d      = drop_q;

        if (frame_valid) begin
            rep_cnt_d = 4'd0;
            tmo_d     = '0;
            if (frame_ok_s) begin
                push_d      = 1'b1;
                push_data_d = {cmd_s, 1'b0};
                last_cmd_d  = cmd_s;
                state_d     = ST_HELD;
            end else begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_HELD: begin
                    if (repeat_valid) begin
                        tmo_d = '0;
                        if (rep_cnt_q != 4'hF) begin
                            rep_cnt_d = rep_cnt_q + 4'd1;
                        end else begin
                            rep_cnt_d = rep_cnt_q;
                        end
                        if (int'({28'd0, rep_cnt_q}) >= REPEAT_DELAY) begin
                            push_d      = 1'b1;
                            push_data_d = {last_cmd_q, 1'b1};
                        end else begin
                            push_d = 1'b0;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_d     = '0;
                        rep_cnt_d = 4'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A push into a full queue survives only if a pop frees a slot
        if (push_q && fifo_full_s && !pop_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end

        held_d = (state_d == ST_HELD);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_cmd_q  <= 8'd0;
            rep_cnt_q   <= 4'd0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= 9'd0;
            err_q       <= 1'b0;
            held_q      <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            last_cmd_q  <= last_cmd_d;
            rep_cnt_q   <= rep_cnt_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            err_q       <= err_d;
            held_q      <= held_d;
            drop_q      <= drop_d;
        end
    end

    ir_cmd_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (pop_s),
        .pop_data  (fifo_rd_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign cmd_valid  = !fifo_empty_s;
    assign cmd_data   = fifo_rd_s[8:1];
    assign cmd_repeat = fifo_rd_s[0];
    assign err_pulse  = err_q;
    assign drop_cnt   = drop_q;
    assign key_held   = held_q;

endmodule

// File: tb/tb_ir_cmd_controller.sv
// Scoreboard bench for ir_cmd_controller: expected commands are queued at
// stimulus time and a negedge monitor checks every accepted handshake.
module tb_ir_cmd_controller;
    import ir_pkg::*;

    localparam int HT  = 200;
    localparam int RD  = 3;
    localparam int GAP = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_valid = 1'b0;
    logic [31:0] frame_data = 32'd0;
    logic        repeat_valid = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [7:0]  cmd_data;
    logic        cmd_repeat;
    logic        err_pulse;
    logic [7:0]  drop_cnt;
    logic        key_held;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q [$];

    ir_cmd_controller #(
        .ADDR_MATCH   (8'h00),
        .HOLD_TIMEOUT (HT),
        .REPEAT_DELAY (RD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_valid  (frame_valid),
        .frame_data   (frame_data),
        .repeat_valid (repeat_valid),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_repeat   (cmd_repeat),
        .err_pulse    (err_pulse),
        .drop_cnt     (drop_cnt),
        .key_held     (key_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {a, ~a, c, ~c};
    endfunction

    // Monitor: every accepted command must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", 32'({cmd_data, cmd_repeat}), 32'h1FF);
            end else begin
                check("cmd", 32'({cmd_data, cmd_repeat}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame(input logic [31:0] d);
        frame_data  = d;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic pulse_repeat();
        repeat_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat_valid = 1'b0;
    endtask

    initial begin
        wait_cycles(3);
        @(negedge clk);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_data", 32'({cmd_data, cmd_repeat}), 32'd0);
        check("rst_err", 32'(err_pulse), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        wait_cycles(2);

        // Valid frame: latency N+2, key held
        exp_q.push_back({8'h18, 1'b0});
        pulse_frame(32'h00FF_18E7);
        @(negedge clk);
        check("v_err_n1", 32'(err_pulse), 32'd0);
        check("v_valid_n1", 32'(cmd_valid), 32'd0);
        check("v_held", 32'(key_held), 32'd1);
        @(negedge clk);
        check("v_valid_n2", 32'(cmd_valid), 32'd1);
        wait_cycles(3);

        // Invalid command complement
        pulse_frame(32'h00FF_18E6);
        @(negedge clk);
        check("bad_err_n1", 32'(err_pulse), 32'd1);
        check("bad_held", 32'(key_held), 32'd0);
        @(negedge clk);
        check("bad_err_n2", 32'(err_pulse), 32'd0);
        check("bad_no_valid", 32'(cmd_valid), 32'd0);
        wait_cycles(2);

        // Frame plus five repeats; only repeats 4 and 5 are emitted
        exp_q.push_back({8'h30, 1'b0});
        pulse_frame(mk(8'h00, 8'h30));
        for (int i = 1; i <= 5; i++) begin
            wait_cycles(GAP);
            if (i > RD) exp_q.push_back({8'h30, 1'b1});
            pulse_repeat();
        end
        wait_cycles(5);
        check("rep_held", 32'(key_held), 32'd1);

        // Timeout release, then a stray repeat is ignored
        wait_cycles(HT + 5);
        check("tmo_held", 32'(key_held), 32'd0);
        pulse_repeat();
        wait_cycles(5);
        check("idle_rep_valid", 32'(cmd_valid), 32'd0);
        check("idle_rep_err", 32'(err_pulse), 32'd0);

        // Exact timeout boundary
        exp_q.push_back({8'h42, 1'b0});
        pulse_frame(mk(8'h00, 8'h42));
        wait_cycles(HT - 1);
        @(negedge clk);
        check("tmo_edge_held", 32'(key_held), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("tmo_edge_rel", 32'(key_held), 32'd0);
        wait_cycles(2);

        // Overflow: six frames with consumer stalled
        cmd_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) exp_q.push_back({8'(i), 1'b0});
            pulse_frame(mk(8'h00, 8'(i)));
        end
        wait_cycles(3);
        @(negedge clk);
        check("ovf_drop", 32'(drop_cnt), 32'd2);
        check("ovf_valid", 32'(cmd_valid), 32'd1);
        check("ovf_head", 32'(cmd_data), 32'h01);
        wait_cycles(2);
        check("ovf_stable", 32'({cmd_data, cmd_repeat}), 32'({8'h01, 1'b0}));
        cmd_ready = 1'b1;
        wait_cycles(8);
        check("ovf_drained", 32'(cmd_valid), 32'd0);

        // Push into a full queue accepted by a same-cycle pop
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back({8'hA1 + 8'(i), 1'b0});
        for (int i = 0; i < 4; i++) pulse_frame(mk(8'h00, 8'hA1 + 8'(i)));
        wait_cycles(3);
        pulse_frame(mk(8'h00, 8'hA5));
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        wait_cycles(2);
        check("full_pop_drop", 32'(drop_cnt), 32'd2);
        cmd_ready = 1'b1;
        wait_cycles(8);

        // Frame and repeat together: frame wins and resets the repeat count
        exp_q.push_back({8'h55, 1'b0});
        repeat_valid = 1'b1;
        pulse_frame(mk(8'h00, 8'h55));
        repeat_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wait_cycles(5);
            if (i > RD) exp_q.push_back({8'h55, 1'b1});
            pulse_repeat();
        end
        wait_cycles(5);

        // Address field handling
`ifdef IR_ADDR_FILTER_EN
        pulse_frame(32'h01FE_18E7);
        @(negedge clk);
        check("addr_err", 32'(err_pulse), 32'd1);
`else
        exp_q.push_back({8'h18, 1'b0});
        pulse_frame(32'h01FE_18E7);
        @(negedge clk);
        check("addr_ignored_err", 32'(err_pulse), 32'd0);
`endif
        wait_cycles(5);

        // Reset with a frame in flight discards it
        pulse_frame(mk(8'h00, 8'h77));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(4);
        check("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_held", 32'(key_held), 32'd0);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
